// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: state encoding and default sizes shared by the I/D memory arbiter
package mem_arbiter_pkg;
  localparam int DATA_W_DEF       = 16;
  localparam int STARVE_LIMIT_DEF = 4;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } arb_state_e;
endpackage

// File: rtl/mem_arbiter_starve_ctr.sv
// mem_arbiter_starve_ctr: saturating count of D-grants taken while the I-side waits
module mem_arbiter_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign sat   = cnt_q == W'(LIMIT);
  assign cnt_d = clr ? '0 : (inc && !sat) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one mem_system between fetch (I, read-only) and memory (D) stages,
// D-side priority with a starvation guard that forces an I grant after STARVE_LIMIT D grants.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rd,
  input  logic [DATA_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  output logic              i_stall,
  output logic              i_hit,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  output logic              d_hit,
  output logic              err,
  output logic [DATA_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_rd,
  output logic              m_wr,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_done,
  input  logic              m_stall,
  input  logic              m_hit,
  input  logic              m_err
);
  arb_state_e        state_q, state_d;
  logic [DATA_W-1:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
  logic              m_rd_q, m_rd_d, m_wr_q, m_wr_d;
  logic              idle, d_req, sat, ent_i, ent_d, hold;
  logic              unused_m_stall;
  assign unused_m_stall = m_stall;
  assign idle  = state_q == IDLE;
  assign d_req = (d_rd | d_wr) & ~(d_rd & d_wr);
  // Grant decision and request latching happen together so m_* appear one cycle after the IDLE request.
  always_comb begin
    state_d   = idle ? ((d_req && !(i_rd && sat)) ? GNT_D : i_rd ? GNT_I : IDLE)
                     : m_done ? IDLE : state_q;
    ent_i     = idle && state_d == GNT_I;
    ent_d     = idle && state_d == GNT_D;
    hold      = !idle && !m_done;
    m_rd_d    = ent_i || (ent_d && d_rd) || (hold && m_rd_q);
    m_wr_d    = (ent_d && d_wr) || (hold && m_wr_q);
    m_addr_d  = ent_i ? i_addr : ent_d ? d_addr : m_addr_q;
    m_wdata_d = ent_d ? d_wdata : m_wdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_rd_q    <= 1'b0;
      m_wr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_rd_q    <= m_rd_d;
      m_wr_q    <= m_wr_d;
    end
  end
  mem_arbiter_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (ent_d & i_rd),
    .clr (ent_i | (idle & ~i_rd)),
    .sat (sat)
  );
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_rd    = m_rd_q;
  assign m_wr    = m_wr_q;
  assign i_done  = state_q == GNT_I && m_done;
  assign d_done  = state_q == GNT_D && m_done;
  assign i_rdata = i_done ? m_rdata : '0;
  assign d_rdata = d_done ? m_rdata : '0;
  assign i_hit   = i_done & m_hit;
  assign d_hit   = d_done & m_hit;
  assign i_stall = i_rd & ~i_done;
  assign d_stall = (d_rd | d_wr) & ~d_done;
  assign err     = (!idle && m_err) || (idle && d_rd && d_wr);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table vectors, hand sequences for multi-cycle corners, and a randomized
// requester/memory environment checked against a transaction-level arbitration model.
module tb_mem_arbiter;
  localparam int LIM = 4;
  logic        clk, rst;
  logic        i_rd, d_rd, d_wr, m_done, m_stall, m_hit, m_err;
  logic [15:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [15:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_done, i_stall, i_hit, d_done, d_stall, d_hit, err, m_rd, m_wr;
  int          n_chk, n_fail;

  mem_arbiter #(.DATA_W(16), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .i_rd(i_rd), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall), .i_hit(i_hit),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_done(d_done), .d_stall(d_stall), .d_hit(d_hit), .err(err),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rd(m_rd), .m_wr(m_wr),
    .m_rdata(m_rdata), .m_done(m_done), .m_stall(m_stall), .m_hit(m_hit), .m_err(m_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

  typedef struct {
    logic [5:0]  in_f;
    logic [15:0] rdata;
    logic [7:0]  ex_f;
    logic [15:0] e_addr;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t  tv[17];
  string fn[7] = '{"m_rd", "m_wr", "i_done", "d_done", "i_stall", "d_stall", "err"};

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; i_rd = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    m_done = 1'b0; m_err = 1'b0; m_hit = 1'b0; m_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic        i_pend, d_pend, d_isw, busy, g_i, g_wr, md, me, mh, last_i, resp;
  logic [15:0] i_a, d_a, d_w, g_a, g_w, mr;
  logic [4:0]  kinds;
  int          wcnt, lat, d_run, gcount;

  initial begin
    n_chk = 0; n_fail = 0; m_stall = 1'b0;
    i_addr = 16'h0040; d_addr = 16'h0100; d_wdata = 16'h1234;
    //             in: i_rd d_rd d_wr m_done m_err m_hit | ex: m_rd m_wr i_done d_done i_stall d_stall err hit
    tv[0]  = '{6'b100000, 16'h0000, 8'b00001000, 16'h0000, 16'h0000};
    tv[1]  = '{6'b100000, 16'h0000, 8'b10001000, 16'h0040, 16'h0000};
    tv[2]  = '{6'b100000, 16'h0000, 8'b10001000, 16'h0040, 16'h0000};
    tv[3]  = '{6'b100101, 16'hBEEF, 8'b10100001, 16'h0040, 16'hBEEF};
    tv[4]  = '{6'b000000, 16'h0000, 8'b00000000, 16'h0000, 16'h0000};
    tv[5]  = '{6'b101000, 16'h0000, 8'b00001100, 16'h0000, 16'h0000};
    tv[6]  = '{6'b101000, 16'h0000, 8'b01001100, 16'h0100, 16'h0000};
    tv[7]  = '{6'b101100, 16'h0000, 8'b01011000, 16'h0100, 16'h0000};
    tv[8]  = '{6'b100000, 16'h0000, 8'b00001000, 16'h0000, 16'h0000};
    tv[9]  = '{6'b100000, 16'h0000, 8'b10001000, 16'h0040, 16'h0000};
    tv[10] = '{6'b110110, 16'hCAFE, 8'b10100110, 16'h0040, 16'hCAFE};
    tv[11] = '{6'b010000, 16'h0000, 8'b00000100, 16'h0000, 16'h0000};
    tv[12] = '{6'b010010, 16'h0000, 8'b10000110, 16'h0100, 16'h0000};
    tv[13] = '{6'b010101, 16'hA5A5, 8'b10010001, 16'h0100, 16'hA5A5};
    tv[14] = '{6'b011000, 16'h0000, 8'b00000110, 16'h0000, 16'h0000};
    tv[15] = '{6'b011000, 16'h0000, 8'b00000110, 16'h0000, 16'h0000};
    tv[16] = '{6'b000000, 16'h0000, 8'b00000000, 16'h0000, 16'h0000};

    do_reset();
    @(negedge clk);
    chk1("reset m_rd", m_rd, 1'b0);
    chk1("reset m_wr", m_wr, 1'b0);
    chk16("reset m_addr", m_addr, 16'h0000);
    chk16("reset m_wdata", m_wdata, 16'h0000);
    chk1("reset i_done", i_done, 1'b0);
    chk1("reset d_done", d_done, 1'b0);
    chk1("reset err", err, 1'b0);

    for (int k = 0; k < 17; k++) begin
      logic [6:0] act;
      @(posedge clk); #1;
      {i_rd, d_rd, d_wr, m_done, m_err, m_hit} = tv[k].in_f;
      m_rdata = tv[k].rdata;
      @(negedge clk);
      act = {m_rd, m_wr, i_done, d_done, i_stall, d_stall, err};
      for (int j = 0; j < 7; j++)
        chk1($sformatf("vec%0d %s", k, fn[j]), act[6-j], tv[k].ex_f[7-j]);
      if (tv[k].ex_f[7] || tv[k].ex_f[6]) chk16($sformatf("vec%0d m_addr", k), m_addr, tv[k].e_addr);
      if (tv[k].ex_f[6]) chk16($sformatf("vec%0d m_wdata", k), m_wdata, 16'h1234);
      if (tv[k].ex_f[5]) begin
        chk16($sformatf("vec%0d i_rdata", k), i_rdata, tv[k].e_rdata);
        chk1($sformatf("vec%0d i_hit", k), i_hit, tv[k].ex_f[0]);
        chk16($sformatf("vec%0d d_rdata idle side", k), d_rdata, 16'h0000);
      end
      if (tv[k].ex_f[4]) begin
        if (!tv[k].in_f[3]) chk16($sformatf("vec%0d d_rdata", k), d_rdata, tv[k].e_rdata);
        chk1($sformatf("vec%0d d_hit", k), d_hit, tv[k].ex_f[0]);
      end
    end

    // Starvation: both sides request continuously; expect D,D,D,D then I.
    do_reset();
    i_addr = 16'h0040; d_addr = 16'h0100;
    gcount = 0; resp = 1'b0; kinds = '0; last_i = 1'b0;
    for (int c = 0; c < 80 && !(gcount == 5 && !resp); c++) begin
      @(posedge clk); #1;
      i_rd = 1'b1; d_rd = 1'b1; d_wr = 1'b0;
      m_done = resp; m_rdata = 16'h1000;
      @(negedge clk);
      if (resp) begin
        resp = 1'b0;
        chk1("starve i_done", i_done, last_i);
        chk1("starve d_done", d_done, !last_i);
      end else if (m_rd) begin
        last_i = m_addr == 16'h0040;
        kinds[gcount] = last_i;
        gcount++;
        resp = 1'b1;
      end
    end
    chk16("starve grant count", 16'(gcount), 16'd5);
    chk16("starve grant order", {11'b0, kinds}, 16'h0010);

    // Reset during the second wait cycle of a D write.
    do_reset();
    @(posedge clk); #1;
    d_wr = 1'b1; d_addr = 16'h0200; d_wdata = 16'h7777;
    @(negedge clk); chk1("rstmid idle m_wr", m_wr, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("rstmid gnt m_wr", m_wr, 1'b1);
    chk16("rstmid gnt m_addr", m_addr, 16'h0200);
    chk16("rstmid gnt m_wdata", m_wdata, 16'h7777);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); chk1("rstmid wait2 d_done", d_done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; d_wr = 1'b0; m_done = 1'b1;
    @(negedge clk);
    chk1("rstmid after m_wr", m_wr, 1'b0);
    chk1("rstmid after m_rd", m_rd, 1'b0);
    chk1("rstmid after d_done", d_done, 1'b0);
    @(posedge clk); #1 m_done = 1'b0;

    // Randomized traffic against a transaction-level arbitration model.
    do_reset();
    i_pend = 0; d_pend = 0; d_isw = 0; busy = 0; d_run = 0; wcnt = 0; lat = 0;
    g_i = 0; g_wr = 0; i_a = '0; d_a = '0; d_w = '0; g_a = '0; g_w = '0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (!i_pend && $urandom_range(0, 1) == 1) begin i_pend = 1'b1; i_a = 16'($urandom); end
      if (!d_pend && $urandom_range(0, 1) == 1) begin
        d_pend = 1'b1; d_isw = 1'($urandom); d_a = 16'($urandom); d_w = 16'($urandom);
      end
      md = busy && wcnt == lat; mr = 16'($urandom); mh = 1'($urandom); me = $urandom_range(0, 7) == 0;
      i_rd = i_pend; i_addr = i_a; d_rd = d_pend & ~d_isw; d_wr = d_pend & d_isw;
      d_addr = d_a; d_wdata = d_w; m_done = md; m_rdata = mr; m_hit = mh; m_err = me;
      @(negedge clk);
      if (!busy) begin
        chk1("rnd idle m_rd", m_rd, 1'b0);
        chk1("rnd idle m_wr", m_wr, 1'b0);
        chk1("rnd idle err", err, 1'b0);
        chk1("rnd idle i_done", i_done, 1'b0);
        chk1("rnd idle d_done", d_done, 1'b0);
        chk1("rnd idle i_stall", i_stall, i_pend);
        chk1("rnd idle d_stall", d_stall, d_pend);
        g_i = (i_pend && d_pend) ? (d_run == LIM) : i_pend;
        if (i_pend || d_pend) begin
          busy = 1'b1; wcnt = 0; lat = $urandom_range(0, 3);
          g_wr = !g_i && d_isw; g_a = g_i ? i_a : d_a; g_w = d_w;
        end
        if (!i_pend || g_i) d_run = 0;
        else if (d_run < LIM) d_run++;
      end else begin
        chk1("rnd m_rd", m_rd, !g_wr);
        chk1("rnd m_wr", m_wr, g_wr);
        chk16("rnd m_addr", m_addr, g_a);
        if (g_wr) chk16("rnd m_wdata", m_wdata, g_w);
        chk1("rnd err", err, me);
        chk1("rnd i_done", i_done, md && g_i);
        chk1("rnd d_done", d_done, md && !g_i);
        chk1("rnd i_stall", i_stall, i_pend && !(md && g_i));
        chk1("rnd d_stall", d_stall, d_pend && !(md && !g_i));
        if (md) begin
          if (g_i) begin
            chk16("rnd i_rdata", i_rdata, mr);
            chk1("rnd i_hit", i_hit, mh);
            i_pend = 1'b0;
          end else begin
            if (!g_wr) chk16("rnd d_rdata", d_rdata, mr);
            chk1("rnd d_hit", d_hit, mh);
            d_pend = 1'b0;
          end
          busy = 1'b0;
        end else wcnt++;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
